// File: rtl/maskbus_pkg.sv
// Shared constants for the mask bus: operation selects and rotation directions.
package maskbus_pkg;

  localparam logic [1:0] MODE_XOR  = 2'd0;
  localparam logic [1:0] MODE_AND  = 2'd1;
  localparam logic [1:0] MODE_OR   = 2'd2;
  localparam logic [1:0] MODE_PASS = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/maskbus_tick.sv
// Rotation-rate divider: asserts o_step combinationally on the last count of each
// DIV-clock period while enabled; disable or clear restarts the period.
module maskbus_tick #(
  parameter int DIV = 4,
  parameter int CW  = 24
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_step
);

  logic [CW-1:0] count_r;
  logic          last_s;

  assign last_s = (count_r == CW'(DIV - 1));
  assign o_step = i_en && last_s;

  // Divider counter: a clear or disable discards any partial count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_r <= '0;
    end else if (i_clr || !i_en) begin
      count_r <= '0;
    end else if (last_s) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

endmodule

// File: rtl/maskbus_rot.sv
// Switch/mask combiner with a loadable, self-rotating mask and registered LED output.
module maskbus_rot
  import maskbus_pkg::*;
#(
  parameter int              WIDTH        = 9,
  parameter logic [WIDTH-1:0] DEFAULT_MASK = WIDTH'(9'h087),
  parameter int              DIV          = 4,
  parameter int              CW           = 24
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_sw,
  input  logic [1:0]       i_mode,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rot,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_led,
  output logic [WIDTH-1:0] o_mask,
  output logic             o_tick
);

  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] led_r;
  logic             tick_r;
  logic             step_s;
  logic             step_apply_s;
  logic [WIDTH-1:0] rot_mask_s;
  logic [WIDTH-1:0] mask_next_s;
  logic [WIDTH-1:0] led_next_s;

  maskbus_tick #(
    .DIV (DIV),
    .CW  (CW)
  ) u_tick (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (i_rot),
    .i_clr     (i_wr),
    .o_step    (step_s)
  );

  // A write on the step cycle suppresses both the rotation and its tick.
  assign step_apply_s = step_s && !i_wr;

  // Rotated mask in the requested direction.
  always_comb begin
    rot_mask_s = mask_r;
    if (i_dir == DIR_RIGHT) begin
      rot_mask_s = {mask_r[0], mask_r[WIDTH-1:1]};
    end else begin
      rot_mask_s = {mask_r[WIDTH-2:0], mask_r[WIDTH-1]};
    end
  end

  // Mask update priority: load, then rotation step, then hold.
  always_comb begin
    mask_next_s = mask_r;
    if (i_wr) begin
      mask_next_s = i_data;
    end else if (step_apply_s) begin
      mask_next_s = rot_mask_s;
    end else begin
      mask_next_s = mask_r;
    end
  end

  // Bitwise operation against the pre-update mask.
  always_comb begin
    led_next_s = '0;
    case (i_mode)
      MODE_XOR:  led_next_s = i_sw ^ mask_r;
      MODE_AND:  led_next_s = i_sw & mask_r;
      MODE_OR:   led_next_s = i_sw | mask_r;
      MODE_PASS: led_next_s = i_sw;
      default:   led_next_s = i_sw;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mask_r <= DEFAULT_MASK;
      led_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      mask_r <= mask_next_s;
      led_r  <= led_next_s;
      tick_r <= step_apply_s;
    end
  end

  assign o_led  = led_r;
  assign o_mask = mask_r;
  assign o_tick = tick_r;

endmodule

// File: tb/tb_maskbus_rot.sv
// Self-checking bench for maskbus_rot: directed scenarios plus randomized traffic
// compared each cycle against a cycle-level behavioural model.
module tb_maskbus_rot;

  localparam int W   = 9;
  localparam int DIV = 4;
  localparam int CW  = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw = '0;
  logic [1:0]   mode = 2'd0;
  logic         wr = 1'b0;
  logic [W-1:0] data = '0;
  logic         rot = 1'b0;
  logic         dir = 1'b0;
  logic [W-1:0] led;
  logic [W-1:0] mask;
  logic         tick;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [W-1:0] m_mask;
  logic [W-1:0] m_led;
  logic         m_tick;
  int           m_cnt;

  maskbus_rot #(.WIDTH(W), .DEFAULT_MASK(9'h087), .DIV(DIV), .CW(CW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_sw(sw), .i_mode(mode), .i_wr(wr),
    .i_data(data), .i_rot(rot), .i_dir(dir), .o_led(led), .o_mask(mask), .o_tick(tick)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] op(input logic [W-1:0] s, input logic [W-1:0] m,
                                      input logic [1:0] md);
    case (md)
      2'd0:    return s ^ m;
      2'd1:    return s & m;
      2'd2:    return s | m;
      default: return s;
    endcase
  endfunction

  function automatic logic [W-1:0] rotate(input logic [W-1:0] m, input logic d);
    logic [W-1:0] r;
    if (d) r = (m >> 1) | (m << (W - 1));
    else   r = (m << 1) | (m >> (W - 1));
    return r;
  endfunction

  task automatic model_reset();
    m_mask = 9'h087;
    m_led  = '0;
    m_tick = 1'b0;
    m_cnt  = 0;
  endtask

  // One clock: model evaluates current inputs, then DUT is sampled 1ns after the edge.
  task automatic cyc();
    logic [W-1:0] nm;
    logic [W-1:0] nl;
    logic         nt;
    int           nc;
    nl = op(sw, m_mask, mode);
    nm = m_mask;
    nt = 1'b0;
    nc = 0;
    if (wr) begin
      nm = data;
    end else if (rot) begin
      if (m_cnt == DIV - 1) begin
        nm = rotate(m_mask, dir);
        nt = 1'b1;
      end else begin
        nc = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
    m_mask = nm; m_led = nl; m_tick = nt; m_cnt = nc;
  endtask

  task automatic check_all(input string name);
    n_cmp++;
    if (mask !== m_mask) begin
      n_fail++;
      $display("FAIL %s mask: got %h expected %h", name, mask, m_mask);
    end
    n_cmp++;
    if (led !== m_led) begin
      n_fail++;
      $display("FAIL %s led: got %h expected %h", name, led, m_led);
    end
    n_cmp++;
    if (tick !== m_tick) begin
      n_fail++;
      $display("FAIL %s tick: got %b expected %b", name, tick, m_tick);
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    wr = 1'b1; data = v;
    cyc();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw = 9'h1FF; mode = 2'd0; rot = 1'b0; wr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (mask !== 9'h087 || led !== 9'h000 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got mask=%h led=%h tick=%b expected 087/000/0", mask, led, tick);
    end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (led !== 9'h178) begin
        n_fail++;
        $display("FAIL reset_release_led: got %h expected 178", led);
      end
      check_all("reset_release");
    end
  endtask

  task automatic test_modes();
    logic [W-1:0] exp_tab [4];
    exp_tab[0] = 9'h077; exp_tab[1] = 9'h080; exp_tab[2] = 9'h0F7; exp_tab[3] = 9'h0F0;
    sw = 9'h0F0;
    for (int md = 0; md < 4; md++) begin
      mode = md[1:0];
      cyc();
      n_cmp++;
      if (led !== exp_tab[md]) begin
        n_fail++;
        $display("FAIL mode_%0d: got %h expected %h", md, led, exp_tab[md]);
      end
    end
    mode = 2'd0;
  endtask

  task automatic test_rotate(input logic d, input logic [W-1:0] e1, input logic [W-1:0] e2,
                             input string name);
    rot = 1'b1; dir = d;
    load(9'h101);
    n_cmp++;
    if (mask !== 9'h101) begin
      n_fail++;
      $display("FAIL %s_load: got %h expected 101", name, mask);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check_all(name);
      if (i == 4 || i == 8) begin
        n_cmp++;
        if (mask !== ((i == 4) ? e1 : e2) || tick !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_step%0d: got mask=%h tick=%b expected %h/1", name, i, mask, tick,
                   (i == 4) ? e1 : e2);
        end
      end
    end
    rot = 1'b0;
    cyc();
  endtask

  task automatic test_write_collision();
    rot = 1'b1; dir = 1'b0;
    load(9'h101);
    repeat (3) begin cyc(); check_all("coll_pre"); end
    wr = 1'b1; data = 9'h0AA;
    cyc();
    wr = 1'b0;
    n_cmp++;
    if (mask !== 9'h0AA || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_write: got mask=%h tick=%b expected 0aa/0", mask, tick);
    end
    repeat (3) begin cyc(); check_all("coll_post"); end
    cyc();
    n_cmp++;
    if (mask !== 9'h154 || tick !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_next_step: got mask=%h tick=%b expected 154/1", mask, tick);
    end
    rot = 1'b0;
    cyc();
  endtask

  task automatic test_rot_drop();
    rot = 1'b1; dir = 1'b0;
    load(9'h001);
    repeat (2) begin cyc(); check_all("drop_pre"); end
    rot = 1'b0;
    cyc();
    rot = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check_all("drop_resume");
      n_cmp++;
      if (tick !== (i == 4)) begin
        n_fail++;
        $display("FAIL drop_tick_clk%0d: got %b expected %b", i, tick, (i == 4));
      end
    end
    n_cmp++;
    if (mask !== 9'h002) begin
      n_fail++;
      $display("FAIL drop_mask: got %h expected 002", mask);
    end
  endtask

  task automatic test_async_reset();
    rot = 1'b1; sw = 9'h1FF; mode = 2'd2;
    load(9'h0F0);
    repeat (2) cyc();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (mask !== 9'h087 || led !== 9'h000 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got mask=%h led=%h tick=%b expected 087/000/0", mask, led, tick);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check_all("after_reset");
    end
    rot = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sw   = W'($urandom);
      mode = 2'($urandom_range(0, 3));
      wr   = ($urandom_range(0, 9) == 0);
      data = W'($urandom);
      if ($urandom_range(0, 19) == 0) data = ($urandom_range(0, 1) != 0) ? 9'h1FF : 9'h000;
      rot  = ($urandom_range(0, 9) != 0);
      dir  = 1'($urandom_range(0, 1));
      cyc();
      check_all("random");
    end
    wr = 1'b0; rot = 1'b0;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_rotate(1'b0, 9'h003, 9'h006, "rot_left");
    test_rotate(1'b1, 9'h180, 9'h0C0, "rot_right");
    test_write_collision();
    test_rot_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
